// File: rtl/texture_fetch_arbiter_if.sv
// Bundle between the texture fetch requesters, the shared texture ROM and the arbiter.
// Handshake: a request i is taken on a rising edge where req_valid[i] & req_ready[i]; rsp_valid[i] qualifies rsp_data.
interface texture_fetch_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [1:0]        req_valid;
    logic [3:0]        req_u0;
    logic [3:0]        req_v0;
    logic [3:0]        req_u1;
    logic [3:0]        req_v1;
    logic              prio_fixed;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_u0, req_v0, req_u1, req_v1, prio_fixed, rom_q,
        input  req_ready, rom_address, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_u0, req_v0, req_u1, req_v1, prio_fixed, rom_q,
        output req_ready, rom_address, rsp_valid, rsp_data
    );
endinterface

// File: rtl/texture_fetch_arbiter.sv
// Two-requester arbiter in front of a synchronous texture ROM; one fetch accepted per cycle,
// response returned exactly two cycles after the accepting edge, in acceptance order.
module texture_fetch_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    texture_fetch_arbiter_if.slave  bus
);
    logic              last_grant_q, last_grant_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_tag_q, s1_tag_d;
    logic              s2_valid_q, s2_tag_q;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        grant;
    logic              accept;
    logic              win;

    // On a tie, round-robin favours whoever did not win last; reset leaves last=1 so requester 0 wins first.
    always_comb begin
        grant = 2'b00;
        if (reset_n) begin
            if (&bus.req_valid) begin
                grant = (bus.prio_fixed || last_grant_q) ? 2'b01 : 2'b10;
            end else begin
                grant = bus.req_valid;
            end
        end
    end

    assign accept = |grant;
    assign win    = grant[1];

    always_comb begin
        last_grant_d  = last_grant_q;
        rom_address_d = rom_address_q;
        s1_valid_d    = accept;
        s1_tag_d      = s1_tag_q;
        rsp_valid_d   = 2'b00;
        rsp_data_d    = rsp_data_q;
        if (accept) begin
            last_grant_d  = win;
            s1_tag_d      = win;
            rom_address_d = win ? ADDR_W'({bus.req_v1, bus.req_u1})
                                : ADDR_W'({bus.req_v0, bus.req_u0});
        end
        if (s2_valid_q) begin
            rsp_valid_d = s2_tag_q ? 2'b10 : 2'b01;
            rsp_data_d  = bus.rom_q;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            last_grant_q  <= 1'b1;
            rom_address_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_tag_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_tag_q      <= 1'b0;
            rsp_valid_q   <= 2'b00;
            rsp_data_q    <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            rom_address_q <= rom_address_d;
            s1_valid_q    <= s1_valid_d;
            s1_tag_q      <= s1_tag_d;
            s2_valid_q    <= s1_valid_q;
            s2_tag_q      <= s1_tag_q;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.rom_address = rom_address_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_texture_fetch_arbiter.sv
// Directed plus randomized bench for texture_fetch_arbiter against a queue-based reference model.
module tb_texture_fetch_arbiter;
    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    texture_fetch_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    texture_fetch_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    // Synchronous ROM: data appears the cycle after the address is presented.
    always @(posedge vga_clk) bus.rom_q <= bus.rom_address ^ 8'hA5;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int model_last = 1;
    logic [7:0] model_addr = 8'h00;
    logic [7:0] model_data = 8'h00;
    int acc1 = 0;
    int pulses = 0;

    int         due_q[$];
    int         tag_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a falling edge; one call covers one rising edge.
    task automatic step(input logic rst, input logic [1:0] v,
                        input logic [3:0] u0, input logic [3:0] v0,
                        input logic [3:0] u1, input logic [3:0] v1,
                        input logic pf);
        int win;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        logic [7:0] a;
        reset_n        = ~rst;
        bus.req_valid  = v;
        bus.req_u0     = u0;
        bus.req_v0     = v0;
        bus.req_u1     = u1;
        bus.req_v1     = v1;
        bus.prio_fixed = pf;
        #1;
        win = -1;
        if (!rst) begin
            if (v == 2'b11)   win = pf ? 0 : 1 - model_last;
            else if (v[0])    win = 0;
            else if (v[1])    win = 1;
        end
        exp_rdy = (win < 0) ? 2'b00 : (win == 0 ? 2'b01 : 2'b10);
        chk("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_rdy});
        @(posedge vga_clk);
        edge_n++;
        if (rst) begin
            due_q.delete();
            tag_q.delete();
            exp_q.delete();
            model_last = 1;
            model_addr = 8'h00;
            model_data = 8'h00;
        end else if (win >= 0) begin
            a = (win == 1) ? {v1, u1} : {v0, u0};
            model_addr = a;
            model_last = win;
            if (win == 1) acc1++;
            due_q.push_back(edge_n + 2);
            tag_q.push_back(win);
            exp_q.push_back(a ^ 8'hA5);
        end
        #1;
        chk("rom_address", {24'd0, bus.rom_address}, {24'd0, model_addr});
        exp_rsp = 2'b00;
        if (due_q.size() > 0 && due_q[0] == edge_n) begin
            void'(due_q.pop_front());
            exp_rsp = (tag_q.pop_front() == 1) ? 2'b10 : 2'b01;
            model_data = exp_q.pop_front();
            pulses++;
        end
        chk("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, exp_rsp});
        chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, model_data});
        @(negedge vga_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        int p0;
        bus.req_valid  = 2'b00;
        bus.req_u0     = 4'd0;
        bus.req_v0     = 4'd0;
        bus.req_u1     = 4'd0;
        bus.req_v1     = 4'd0;
        bus.prio_fixed = 1'b0;
        @(negedge vga_clk);

        // Reset state
        step(1'b1, 2'b11, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        step(1'b1, 2'b01, 4'd5, 4'd6, 4'd7, 4'd8, 1'b1);

        // Single request: u0=3, v0=2 -> address 0x23, data 0x86
        step(1'b0, 2'b01, 4'd3, 4'd2, 4'd0, 4'd0, 1'b0);
        chk("req030_addr", {24'd0, bus.rom_address}, 32'h23);
        idle(2);
        chk("req030_data", {24'd0, bus.rsp_data}, 32'h86);
        chk("req030_valid", {30'd0, bus.rsp_valid}, 32'h1);
        idle(1);

        // Round-robin contention, 4 cycles
        for (int i = 0; i < 4; i++)
            step(1'b0, 2'b11, 4'(i), 4'd1, 4'(i + 8), 4'd9, 1'b0);
        idle(3);

        // Fixed priority contention, requester 1 must never win
        p0 = acc1;
        for (int i = 0; i < 3; i++)
            step(1'b0, 2'b11, 4'(i), 4'd4, 4'd15, 4'd15, 1'b1);
        chk("req032_no_req1", 32'(acc1 - p0), 32'd0);
        idle(3);

        // Coordinate boundaries
        step(1'b0, 2'b10, 4'd0, 4'd0, 4'd15, 4'd15, 1'b0);
        chk("req033_addr_ff", {24'd0, bus.rom_address}, 32'hFF);
        step(1'b0, 2'b01, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("req033_addr_00", {24'd0, bus.rom_address}, 32'h00);
        idle(1);
        chk("req033_data_ff", {24'd0, bus.rsp_data}, 32'h5A);
        idle(2);

        // Reset with two fetches in flight
        step(1'b0, 2'b01, 4'd1, 4'd1, 4'd0, 4'd0, 1'b0);
        step(1'b0, 2'b10, 4'd0, 4'd0, 4'd2, 4'd2, 1'b0);
        step(1'b1, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        idle(4);
        step(1'b0, 2'b11, 4'd6, 4'd6, 4'd7, 4'd7, 1'b0);
        chk("req034_grant0", {24'd0, bus.rom_address}, 32'h66);
        idle(3);

        // Back-to-back stream of 16
        p0 = pulses;
        for (int i = 0; i < 16; i++)
            step(1'b0, 2'b01, 4'(i), 4'(15 - i), 4'd0, 4'd0, 1'b0);
        idle(2);
        chk("req035_pulses", 32'(pulses - p0), 32'd16);
        idle(1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 1)));
        idle(3);
        chk("queue_drained", 32'(due_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
